// File: rtl/buffer_pkg.sv
// buffer_pkg: shared types and constants for the m1 buffer bank.
// Build defaults: `N_BUF banks, `ADDR_RAM word-address bits.
`ifndef N_BUF
`define N_BUF 3
`endif
`ifndef ADDR_RAM
`define ADDR_RAM 8
`endif

package buffer_pkg;
  localparam int BUF_N      = `N_BUF;
  localparam int BUF_ADDR_W = `ADDR_RAM;
  localparam int BUF_DATA_W = 16;
  localparam int BUF_BANK_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_RSP  = 1'b1
  } host_state_t;

  typedef struct packed {
    logic                  we;
    logic [BUF_BANK_W-1:0] bank;
    logic [BUF_ADDR_W-1:0] addr;
    logic [BUF_DATA_W-1:0] wdata;
  } host_req_t;
endpackage

// File: rtl/interface_buffer_m1_ctrl.sv
// interface_buffer_m1_ctrl: per-bank m1 read/write enables and addresses.
// ctrl modport drives (layer controllers), resp modport receives (bank).
interface interface_buffer_m1_ctrl
  import buffer_pkg::*;
#(
  parameter int N_BUF  = BUF_N,
  parameter int ADDR_W = BUF_ADDR_W
);
  logic [N_BUF-1:0]             m1_r_en;
  logic [N_BUF-1:0][ADDR_W-1:0] m1_r_addr;
  logic [N_BUF-1:0]             m1_w_en;
  logic [N_BUF-1:0][ADDR_W-1:0] m1_w_addr;

  modport ctrl (
    output m1_r_en, m1_r_addr,
    output m1_w_en, m1_w_addr
  );

  modport resp (
    input m1_r_en, m1_r_addr,
    input m1_w_en, m1_w_addr
  );
endinterface

// File: rtl/buffer_ram_1r1w.sv
// buffer_ram_1r1w: one bank, sync write, registered sync read.
// i_rsel steers the read into o_hdata (host) instead of o_rdata (m1);
// `BUFFER_M1_RD_BYPASS_EN forwards same-address write data to the read.
module buffer_ram_1r1w #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic              i_rsel,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_hdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] w_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

`ifdef BUFFER_M1_RD_BYPASS_EN
  assign w_q = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
`else
  assign w_q = r_mem[i_raddr];
`endif

  // Separate output registers so a host read never disturbs
  // the held m1 read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata <= '0;
      o_hdata <= '0;
    end else if (i_re) begin
      if (i_rsel) o_hdata <= w_q;
      else        o_rdata <= w_q;
    end
  end
endmodule

// File: rtl/buffer_m1_bank.sv
// buffer_m1_bank: N_BUF 1R1W banks serving the m1 port, plus a host
// load/unload port arbitrated below m1 and a saturating stall counter.
// Ports: clk, rst (async high), intf_m1 (resp), m1_w_data, m1_r_data,
//   host_req_{valid,ready,we,bank,addr,wdata},
//   host_rsp_{valid,ready,rdata,err}, host_stall_cnt.
// Option macro: BUFFER_M1_RD_BYPASS_EN (write-to-read forwarding).
module buffer_m1_bank
  import buffer_pkg::*;
#(
  parameter int N_BUF  = BUF_N,
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = BUF_DATA_W,
  parameter int BANK_W = $clog2(N_BUF)
) (
  input  logic                         clk,
  input  logic                         rst,
  interface_buffer_m1_ctrl.resp        intf_m1,
  input  logic [N_BUF-1:0][DATA_W-1:0] m1_w_data,
  output logic [N_BUF-1:0][DATA_W-1:0] m1_r_data,
  input  logic                         host_req_valid,
  output logic                         host_req_ready,
  input  logic                         host_req_we,
  input  logic [BANK_W-1:0]            host_req_bank,
  input  logic [ADDR_W-1:0]            host_req_addr,
  input  logic [DATA_W-1:0]            host_req_wdata,
  output logic                         host_rsp_valid,
  input  logic                         host_rsp_ready,
  output logic [DATA_W-1:0]            host_rsp_rdata,
  output logic                         host_rsp_err,
  output logic [15:0]                  host_stall_cnt
);
  host_state_t r_state, w_state_nxt;
  logic [BANK_W-1:0] r_rsp_bank;
  logic              r_rsp_err;
  logic [15:0]       r_stall;

  host_req_t                    w_req;
  logic [N_BUF-1:0]             w_m1_any;
  logic [N_BUF-1:0]             w_sel;
  logic [N_BUF-1:0]             w_h_rd;
  logic [N_BUF-1:0]             w_h_wr;
  logic [N_BUF-1:0][DATA_W-1:0] w_hdata;
  logic                         w_bank_ok;
  logic                         w_busy;
  logic                         w_fire;
  logic                         w_rsp_fire;

  assign w_req = '{
    we:    host_req_we,
    bank:  host_req_bank,
    addr:  host_req_addr,
    wdata: host_req_wdata
  };

  assign w_m1_any = intf_m1.m1_r_en | intf_m1.m1_w_en;

  // One-hot bank decode; an out-of-range index selects nothing.
  always_comb begin
    w_sel = '0;
    for (int b = 0; b < N_BUF; b++) begin
      w_sel[b] = (w_req.bank == BANK_W'(b));
    end
  end

  assign w_bank_ok = |w_sel;
  assign w_busy    = |(w_sel & w_m1_any);

  assign host_req_ready = !rst && (r_state == H_IDLE) && !w_busy;
  assign w_fire         = host_req_valid && host_req_ready;
  assign w_h_rd         = (w_fire && !w_req.we) ? w_sel : '0;
  assign w_h_wr         = (w_fire &&  w_req.we) ? w_sel : '0;

  assign host_rsp_valid = (r_state == H_RSP);
  assign w_rsp_fire     = host_rsp_valid && host_rsp_ready;
  assign host_rsp_err   = host_rsp_valid && r_rsp_err;
  assign host_stall_cnt = r_stall;

  always_comb begin
    host_rsp_rdata = '0;
    for (int b = 0; b < N_BUF; b++) begin
      if (host_rsp_valid && !r_rsp_err && (r_rsp_bank == BANK_W'(b)))
        host_rsp_rdata = w_hdata[b];
    end
  end

  for (genvar b = 0; b < N_BUF; b++) begin : g_bank
    logic              w_re;
    logic              w_we;
    logic [ADDR_W-1:0] w_raddr;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // Host only reaches a bank m1 is not touching, so m1 owns the mux.
    assign w_re    = intf_m1.m1_r_en[b] | w_h_rd[b];
    assign w_we    = intf_m1.m1_w_en[b] | w_h_wr[b];
    assign w_raddr = intf_m1.m1_r_en[b] ?
                     intf_m1.m1_r_addr[b][ADDR_W-1:0] : w_req.addr;
    assign w_waddr = intf_m1.m1_w_en[b] ?
                     intf_m1.m1_w_addr[b][ADDR_W-1:0] : w_req.addr;
    assign w_wdata = intf_m1.m1_w_en[b] ? m1_w_data[b] : w_req.wdata;

    buffer_ram_1r1w #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_re    (w_re),
      .i_rsel  (w_h_rd[b]),
      .i_raddr (w_raddr),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .o_rdata (m1_r_data[b]),
      .o_hdata (w_hdata[b])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      H_IDLE: if (w_fire && !w_req.we) w_state_nxt = H_RSP;
      H_RSP:  if (w_rsp_fire)          w_state_nxt = H_IDLE;
      default: w_state_nxt = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= H_IDLE;
      r_rsp_bank <= '0;
      r_rsp_err  <= 1'b0;
      r_stall    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire && !w_req.we) begin
        r_rsp_bank <= w_req.bank;
        r_rsp_err  <= !w_bank_ok;
      end
      if ((r_state == H_IDLE) && host_req_valid && !host_req_ready &&
          (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
    end
  end
endmodule

// File: tb/tb_buffer_m1_bank.sv
// tb_buffer_m1_bank: directed and randomized checks of buffer_m1_bank
// against an array-based memory model of the banks and host port.
module tb_buffer_m1_bank;
  import buffer_pkg::*;

  localparam int NB    = BUF_N;
  localparam int AW    = BUF_ADDR_W;
  localparam int DW    = BUF_DATA_W;
  localparam int BW    = $clog2(NB);
  localparam int DEPTH = 1 << AW;
`ifdef BUFFER_M1_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interface_buffer_m1_ctrl #(.N_BUF(NB), .ADDR_W(AW)) m1 ();

  logic [NB-1:0][DW-1:0] m1_w_data;
  logic [NB-1:0][DW-1:0] m1_r_data;
  logic          host_req_valid, host_req_ready, host_req_we;
  logic [BW-1:0] host_req_bank;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_wdata;
  logic          host_rsp_valid, host_rsp_ready, host_rsp_err;
  logic [DW-1:0] host_rsp_rdata;
  logic [15:0]   host_stall_cnt;

  buffer_m1_bank dut (
    .clk            (clk),
    .rst            (rst),
    .intf_m1        (m1),
    .m1_w_data      (m1_w_data),
    .m1_r_data      (m1_r_data),
    .host_req_valid (host_req_valid),
    .host_req_ready (host_req_ready),
    .host_req_we    (host_req_we),
    .host_req_bank  (host_req_bank),
    .host_req_addr  (host_req_addr),
    .host_req_wdata (host_req_wdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_ready (host_rsp_ready),
    .host_rsp_rdata (host_rsp_rdata),
    .host_rsp_err   (host_rsp_err),
    .host_stall_cnt (host_stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [NB][DEPTH];
  logic [DW-1:0] exp_rd [NB];
  bit            pend;
  bit            exp_err;
  logic [DW-1:0] exp_rsp;
  int            exp_stall;
  int            s0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m1.m1_r_en     = '0;
    m1.m1_w_en     = '0;
    m1.m1_r_addr   = '0;
    m1.m1_w_addr   = '0;
    m1_w_data      = '0;
    host_req_valid = 1'b0;
    host_req_we    = 1'b0;
    host_req_bank  = '0;
    host_req_addr  = '0;
    host_req_wdata = '0;
    host_rsp_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) exp_rd[b] = '0;
    pend      = 1'b0;
    exp_err   = 1'b0;
    exp_rsp   = '0;
    exp_stall = 0;
  endtask

  // One clock: check handshake outputs before the edge, advance the
  // model, step the clock and check registered outputs after it.
  task automatic cyc();
    bit e_rdy;
    bit fire;
    bit busy;
    int bk;
    int ra;
    int wa;
    #1;
    bk   = int'(host_req_bank);
    busy = 1'b0;
    if (bk < NB) busy = m1.m1_r_en[bk] || m1.m1_w_en[bk];
    e_rdy = !pend && !busy;
    chk("req_ready", {31'd0, host_req_ready}, {31'd0, e_rdy});
    chk("rsp_valid", {31'd0, host_rsp_valid}, {31'd0, pend});
    if (pend) begin
      chk("rsp_rdata", {16'd0, host_rsp_rdata}, {16'd0, exp_rsp});
      chk("rsp_err", {31'd0, host_rsp_err}, {31'd0, exp_err});
    end
    fire = host_req_valid && e_rdy;
    if (!pend && host_req_valid && !e_rdy && exp_stall < 65535)
      exp_stall++;
    for (int b = 0; b < NB; b++) begin
      if (m1.m1_r_en[b]) begin
        ra = int'(m1.m1_r_addr[b]);
        wa = int'(m1.m1_w_addr[b]);
        if (BYP && m1.m1_w_en[b] && wa == ra) exp_rd[b] = m1_w_data[b];
        else exp_rd[b] = mem[b][ra];
      end
    end
    if (pend && host_rsp_ready) pend = 1'b0;
    if (fire && !host_req_we) begin
      pend = 1'b1;
      if (bk < NB) begin
        exp_rsp = mem[bk][int'(host_req_addr)];
        exp_err = 1'b0;
      end else begin
        exp_rsp = '0;
        exp_err = 1'b1;
      end
    end
    for (int b = 0; b < NB; b++)
      if (m1.m1_w_en[b]) mem[b][int'(m1.m1_w_addr[b])] = m1_w_data[b];
    if (fire && host_req_we && bk < NB)
      mem[bk][int'(host_req_addr)] = host_req_wdata;
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++)
      chk($sformatf("m1_r_data[%0d]", b), {16'd0, m1_r_data[b]},
          {16'd0, exp_rd[b]});
    chk("stall_cnt", {16'd0, host_stall_cnt}, exp_stall);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    host_req_valid = 1'b1;
    #2;
    for (int b = 0; b < NB; b++)
      chk("rst_m1_r_data", {16'd0, m1_r_data[b]}, 32'd0);
    chk("rst_req_ready", {31'd0, host_req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, host_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, host_rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'd0, host_rsp_err}, 32'd0);
    chk("rst_stall", {16'd0, host_stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    host_req_valid = 1'b0;
    model_reset();

    // Known contents everywhere.
    for (int a = 0; a < DEPTH; a++) begin
      m1.m1_w_en = '1;
      for (int b = 0; b < NB; b++) begin
        m1.m1_w_addr[b] = AW'(a);
        m1_w_data[b]    = DW'($urandom);
      end
      cyc();
    end
    idle();

    // m1 write then read back, 1-cycle latency.
    m1.m1_w_en[2] = 1'b1;
    m1.m1_w_addr[2] = AW'(8'h10);
    m1_w_data[2] = 16'hBEEF;
    cyc();
    idle();
    m1.m1_r_en[2] = 1'b1;
    m1.m1_r_addr[2] = AW'(8'h10);
    cyc();
    idle();
    chk("t1_beef", {16'd0, m1_r_data[2]}, 32'h0000BEEF);

    // Same-cycle read/write collision.
    m1.m1_w_en[0] = 1'b1;
    m1.m1_w_addr[0] = AW'(5);
    m1_w_data[0] = 16'h00AA;
    cyc();
    m1.m1_r_en[0] = 1'b1;
    m1.m1_r_addr[0] = AW'(5);
    m1_w_data[0] = 16'h1234;
    cyc();
    idle();
    chk("t2_collide", {16'd0, m1_r_data[0]},
        BYP ? 32'h00001234 : 32'h000000AA);

    // Host read held under back-pressure.
    host_req_valid = 1'b1;
    host_req_we    = 1'b1;
    host_req_bank  = BW'(1);
    host_req_addr  = AW'(3);
    host_req_wdata = 16'h5A5A;
    cyc();
    host_req_we = 1'b0;
    cyc();
    host_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_valid", {31'd0, host_rsp_valid}, 32'd1);
      chk("t3_rdata", {16'd0, host_rsp_rdata}, 32'h00005A5A);
      chk("t3_ready", {31'd0, host_req_ready}, 32'd0);
    end
    host_rsp_ready = 1'b1;
    cyc();
    host_rsp_ready = 1'b0;
    #1;
    chk("t3_idle", {31'd0, host_req_ready}, 32'd1);
    cyc();

    // Host blocked only on the bank m1 is using.
    s0 = exp_stall;
    m1.m1_r_en[0]   = 1'b1;
    m1.m1_r_addr[0] = AW'(5);
    host_req_valid  = 1'b1;
    host_req_we     = 1'b1;
    host_req_bank   = BW'(0);
    host_req_addr   = AW'(7);
    host_req_wdata  = 16'h7777;
    repeat (3) cyc();
    m1.m1_r_en[0] = 1'b0;
    cyc();
    chk("t4_stall", {16'd0, host_stall_cnt}, 32'(s0 + 3));
    m1.m1_r_en[0] = 1'b1;
    host_req_bank = BW'(1);
    host_req_addr = AW'(9);
    #1;
    chk("t4_other_bank", {31'd0, host_req_ready}, 32'd1);
    cyc();
    idle();

    // Out-of-range bank index.
    host_req_valid = 1'b1;
    host_req_bank  = BW'(NB);
    host_req_addr  = AW'(8'h10);
    cyc();
    host_req_valid = 1'b0;
    chk("t5_err", {31'd0, host_rsp_err}, 32'd1);
    chk("t5_rdata", {16'd0, host_rsp_rdata}, 32'd0);
    host_rsp_ready = 1'b1;
    cyc();
    host_rsp_ready = 1'b0;
    host_req_valid = 1'b1;
    host_req_we    = 1'b1;
    host_req_wdata = 16'h0000;
    cyc();
    idle();
    m1.m1_r_en   = '1;
    for (int b = 0; b < NB; b++) m1.m1_r_addr[b] = AW'(8'h10);
    cyc();
    idle();
    chk("t5_no_write", {16'd0, m1_r_data[2]}, 32'h0000BEEF);

    // Randomized traffic, narrow address range for collisions.
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < NB; b++) begin
        m1.m1_r_en[b]   = ($urandom_range(0, 3) == 0);
        m1.m1_w_en[b]   = ($urandom_range(0, 3) == 0);
        m1.m1_r_addr[b] = AW'($urandom_range(0, 7));
        m1.m1_w_addr[b] = AW'($urandom_range(0, 7));
        m1_w_data[b]    = DW'($urandom);
      end
      host_req_valid = $urandom_range(0, 1) == 1;
      host_req_we    = $urandom_range(0, 1) == 1;
      host_req_bank  = BW'($urandom_range(0, NB));
      host_req_addr  = AW'($urandom_range(0, 7));
      host_req_wdata = DW'($urandom);
      host_rsp_ready = $urandom_range(0, 1) == 1;
      cyc();
    end
    idle();
    host_rsp_ready = 1'b1;
    repeat (2) cyc();
    idle();

    // Reset while a response is pending.
    host_req_valid = 1'b1;
    host_req_bank  = BW'(1);
    host_req_addr  = AW'(3);
    cyc();
    host_req_valid = 1'b0;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rsp_valid", {31'd0, host_rsp_valid}, 32'd0);
    chk("t6_stall", {16'd0, host_stall_cnt}, 32'd0);
    chk("t6_ready", {31'd0, host_req_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    host_req_valid = 1'b1;
    host_req_bank  = BW'(2);
    host_req_addr  = AW'(8'h10);
    #1;
    chk("t6_idle", {31'd0, host_req_ready}, 32'd1);
    cyc();
    host_req_valid = 1'b0;
    chk("t6_keep_data", {16'd0, host_rsp_rdata}, {16'd0, mem[2][16]});
    host_rsp_ready = 1'b1;
    cyc();
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
